kmeans_k2n2_centroid_update: RTL

- Read-back end of the k-means accumulator path.
- After classification finishes, it reads the per-cluster sum memories and takes the per-cluster data counters as inputs.
- For each cluster and dimension it divides the accumulated sum by the member count, producing the new centroid values.
- It pulses up_centroids so the classifier loads the new centroids, and flags convergence when no centroid changes.

---
 rtl/kmeans_pkg.sv | 38 +++
 rtl/kmeans_k2n2_centroid_update_div.sv | 86 ++++++++
 rtl/kmeans_k2n2_centroid_update.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_pkg
// Brief    : Shared state encoding and width derivations for the k-means
//            centroid update path.
// Revision : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

    // Centroid-update controller states. NEXT is a decision point taken on the
    // DIV1 exit edge so the run length stays fixed; the encoding is kept so a
    // stray entry still resolves to a legal successor.
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rd     = 3'd1;
    localparam logic [2:0] c_st_latch  = 3'd2;
    localparam logic [2:0] c_st_div0   = 3'd3;
    localparam logic [2:0] c_st_div1   = 3'd4;
    localparam logic [2:0] c_st_next   = 3'd5;
    localparam logic [2:0] c_st_update = 3'd6;

    function automatic int cnt_width(input int depth_b);
        return depth_b + 1;
    endfunction

    // Cycles from the start-sampling edge to the up_centroids cycle.
    function automatic int cu_latency(input int acc_w);
        return 2 * (2 + 2 * acc_w) + 1;
    endfunction

    localparam int c_latency_default = cu_latency(8);

    // A quotient wider than a centroid must saturate instead of zero-extending.
    function automatic bit quo_needs_sat(input int quo_w, input int data_w);
        return quo_w > data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kmeans_k2n2_centroid_update_div.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_serial_div
// Brief    : Restoring unsigned divider, one quotient bit per cycle. The first
//            bit is resolved on the start edge so a DIVIDEND_W-bit division
//            has done high in the DIVIDEND_W-th cycle after start.
// Revision : 1.0 - initial release
// ============================================================================
module kmeans_serial_div #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int c_cnt_w = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_div;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;

    logic [DIVISOR_W-1:0]  w_src_rem;
    logic [DIVIDEND_W-1:0] w_src_quo;
    logic [DIVISOR_W-1:0]  w_src_div;
    logic [DIVISOR_W:0]    w_trial;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_fits;
    logic [DIVISOR_W-1:0]  w_next_rem;
    logic [DIVIDEND_W-1:0] w_next_quo;
    logic                  w_unused_msb;

    // r_quo shifts dividend bits out of the top while quotient bits enter below.
    always_comb begin
        w_src_rem  = start ? '0 : r_rem;
        w_src_quo  = start ? dividend : r_quo;
        w_src_div  = start ? divisor : r_div;
        w_trial    = {w_src_rem, w_src_quo[DIVIDEND_W-1]};
        w_diff     = w_trial - {1'b0, w_src_div};
        w_fits     = (w_trial >= {1'b0, w_src_div});
        w_next_rem = w_fits ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
        w_next_quo = {w_src_quo[DIVIDEND_W-2:0], w_fits};
    end

    assign w_unused_msb = w_diff[DIVISOR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= w_next_rem;
            r_quo  <= w_next_quo;
            r_div  <= divisor;
            r_cnt  <= c_cnt_w'(1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == c_cnt_w'(DIVIDEND_W)) begin
                r_busy <= 1'b0;
            end else begin
                r_rem <= w_next_rem;
                r_quo <= w_next_quo;
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == c_cnt_w'(DIVIDEND_W));
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/kmeans_k2n2_centroid_update.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_k2n2_centroid_update
// Brief    : Reads back the per-cluster sums (k=2, n=2), divides them by the
//            member counts and strobes the new centroids plus convergence.
//            Option macro KMEANS_CU_ROUND_EN: round-to-nearest quotients.
// Revision : 1.0 - initial release
// ============================================================================
module kmeans_k2n2_centroid_update
    import kmeans_pkg::*;
#(
    parameter int DATA_WIDTH           = 16,
    parameter int N_INPUT_DATA_B_DEPTH = 8,
    parameter int ACC_SUM_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            bck_rd,
    output logic                            bck_rd_addr,
    input  logic [ACC_SUM_WIDTH-1:0]        mem_sum_d0_out,
    input  logic [ACC_SUM_WIDTH-1:0]        mem_sum_d1_out,
    input  logic [N_INPUT_DATA_B_DEPTH:0]   k0_counter,
    input  logic [N_INPUT_DATA_B_DEPTH:0]   k1_counter,
    input  logic [DATA_WIDTH-1:0]           k0_0,
    input  logic [DATA_WIDTH-1:0]           k0_1,
    input  logic [DATA_WIDTH-1:0]           k1_0,
    input  logic [DATA_WIDTH-1:0]           k1_1,
    output logic [DATA_WIDTH-1:0]           k0_0_n,
    output logic [DATA_WIDTH-1:0]           k0_1_n,
    output logic [DATA_WIDTH-1:0]           k1_0_n,
    output logic [DATA_WIDTH-1:0]           k1_1_n,
    output logic                            up_centroids,
    output logic                            converged,
    output logic                            done
);

    localparam int c_cnt_w = cnt_width(N_INPUT_DATA_B_DEPTH);
    localparam int c_quo_w = ACC_SUM_WIDTH + 1;

    logic [2:0]               r_state;
    logic                     r_c;
    logic [ACC_SUM_WIDTH-1:0] r_sum_d1;
    logic [c_cnt_w-1:0]       r_count;
    logic [DATA_WIDTH-1:0]    r_new [4];
    logic [DATA_WIDTH-1:0]    r_kn  [4];
    logic                     r_converged;

    logic [c_cnt_w-1:0]       w_cnt_sel;
    logic [1:0]               w_slot;
    logic [DATA_WIDTH-1:0]    w_cur   [4];
    logic [DATA_WIDTH-1:0]    w_final [4];
    logic [DATA_WIDTH-1:0]    w_map;
    logic [DATA_WIDTH-1:0]    w_res;
    logic [c_quo_w-1:0]       w_q_ext;
    logic                     w_match;

    logic                     w_div_start;
    logic [ACC_SUM_WIDTH-1:0] w_div_dividend;
    logic [c_cnt_w-1:0]       w_div_divisor;
    logic                     w_div_busy;
    logic                     w_div_done;
    logic [ACC_SUM_WIDTH-1:0] w_div_quo;
    logic [c_cnt_w-1:0]       w_div_rem;

    assign w_cnt_sel = r_c ? k1_counter : k0_counter;
    assign w_slot    = {r_c, (r_state == c_st_div1)};

    // d0 goes straight from the memory port into the divider on the LATCH edge;
    // d1 waits in r_sum_d1 until the d0 division finishes.
    assign w_div_start    = (r_state == c_st_latch) ||
                            ((r_state == c_st_div0) && w_div_done);
    assign w_div_dividend = (r_state == c_st_latch) ? mem_sum_d0_out : r_sum_d1;
    assign w_div_divisor  = (r_state == c_st_latch) ? w_cnt_sel : r_count;

    kmeans_serial_div #(
        .DIVIDEND_W (ACC_SUM_WIDTH),
        .DIVISOR_W  (c_cnt_w)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_div_dividend),
        .divisor   (w_div_divisor),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

`ifdef KMEANS_CU_ROUND_EN
    logic w_round_up;
    assign w_round_up = ({w_div_rem, 1'b0} >= {1'b0, r_count});
    assign w_q_ext    = {1'b0, w_div_quo} + {{ACC_SUM_WIDTH{1'b0}}, w_round_up};
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_div_rem;
    assign w_q_ext      = {1'b0, w_div_quo};
`endif

    generate
        if (quo_needs_sat(c_quo_w, DATA_WIDTH)) begin : g_sat
            assign w_map = (|w_q_ext[c_quo_w-1:DATA_WIDTH]) ? '1
                                                             : w_q_ext[DATA_WIDTH-1:0];
        end else begin : g_ext
            assign w_map = DATA_WIDTH'(w_q_ext);
        end
    endgenerate

    always_comb begin
        w_cur[0] = k0_0;
        w_cur[1] = k0_1;
        w_cur[2] = k1_0;
        w_cur[3] = k1_1;
    end

    // An empty cluster keeps its current centroid rather than a divide-by-zero value.
    assign w_res = (r_count == '0) ? w_cur[w_slot] : w_map;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_final
            assign w_final[gi] = (w_slot == 2'(gi)) ? w_res : r_new[gi];
        end
    endgenerate

    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_final[i] != w_cur[i]) begin
                w_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_c         <= 1'b0;
            r_sum_d1    <= '0;
            r_count     <= '0;
            r_converged <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_new[i] <= '0;
                r_kn[i]  <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_rd;
                        r_c         <= 1'b0;
                        r_converged <= 1'b0;
                    end
                end
                c_st_rd: begin
                    r_state <= c_st_latch;
                end
                c_st_latch: begin
                    r_sum_d1 <= mem_sum_d1_out;
                    r_count  <= w_cnt_sel;
                    r_state  <= c_st_div0;
                end
                c_st_div0: begin
                    if (w_div_done) begin
                        r_new[w_slot] <= w_res;
                        r_state       <= c_st_div1;
                    end
                end
                c_st_div1: begin
                    if (w_div_done) begin
                        r_new[w_slot] <= w_res;
                        if (!r_c) begin
                            r_c     <= 1'b1;
                            r_state <= c_st_rd;
                        end else begin
                            // Publish on the entry edge so data is valid with the strobe.
                            for (int i = 0; i < 4; i++) begin
                                r_kn[i] <= w_final[i];
                            end
                            r_converged <= w_match;
                            r_state     <= c_st_update;
                        end
                    end
                end
                c_st_next: begin
                    r_state <= r_c ? c_st_update : c_st_rd;
                end
                c_st_update: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy         = (r_state != c_st_idle) || w_div_busy;
    assign bck_rd       = (r_state == c_st_rd) || (r_state == c_st_latch);
    assign bck_rd_addr  = r_c;
    assign up_centroids = (r_state == c_st_update);
    assign done         = (r_state == c_st_update);
    assign converged    = r_converged;
    assign k0_0_n       = r_kn[0];
    assign k0_1_n       = r_kn[1];
    assign k1_0_n       = r_kn[2];
    assign k1_1_n       = r_kn[3];

endmodule
`default_nettype wire
